// File: rtl/dsp_pkg.sv
// Shared constants and constant-function helpers for the I/Q DAC output stage.
package dsp_pkg;

  localparam int DEF_IN_W  = 12;
  localparam int DEF_OUT_W = 6;
  localparam int D         = DEF_IN_W - DEF_OUT_W;

  function automatic int mid(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_dac_lane.sv
// One channel of the formatter: gain/round/shift in stage 1, clamp-or-wrap and
// offset-binary conversion in stage 2.
module iq_dac_lane
  import dsp_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int MAX_SHIFT = 4,
  parameter int SH_W      = 3,
  parameter int ROUND     = 1,
  parameter int SATURATE  = 1
) (
  input  logic                   pll_clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [SH_W-1:0]        shift,
  input  logic signed [IN_W-1:0] sample,
  input  logic                   advance,
  input  logic                   muted,
  output logic                   ovf,
  output logic [OUT_W-1:0]       dac
);

  localparam int DROP = IN_W - OUT_W;
  localparam int EW   = IN_W + MAX_SHIFT + 1;
  localparam logic signed [EW-1:0] RND  = (ROUND != 0) ? EW'(1 << (DROP - 1)) : '0;
  localparam logic signed [EW-1:0] MAXV = EW'(mid(OUT_W) - 1);
  localparam logic signed [EW-1:0] MINV = EW'(-mid(OUT_W));
  localparam logic [OUT_W-1:0]     MID_CODE = OUT_W'(mid(OUT_W));

  logic signed [EW-1:0] scaled;
  logic signed [EW-1:0] rounded;
  logic signed [EW-1:0] r_next;
  logic                 ovf_next;
  logic [OUT_W-1:0]     r_low;
  logic                 r_neg;
  logic [OUT_W-1:0]     code;

  always_comb begin
    scaled   = EW'(sample) <<< shift;
    rounded  = scaled + RND;
    r_next   = rounded >>> DROP;
    ovf_next = (r_next > MAXV) || (r_next < MINV);
  end

  // Only the low bits and the sign survive stage 1; the sign picks the clamp rail.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      r_low <= '0;
      r_neg <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      r_low <= r_next[OUT_W-1:0];
      r_neg <= r_next[EW-1];
      ovf   <= ovf_next;
    end
  end

  always_comb begin
    code = r_low;
    if ((SATURATE != 0) && ovf) begin
      code = r_neg ? MINV[OUT_W-1:0] : MAXV[OUT_W-1:0];
    end
    code[OUT_W-1] = ~code[OUT_W-1];
  end

  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      dac <= MID_CODE;
    end else if (advance) begin
      dac <= muted ? MID_CODE : code;
    end
  end

endmodule

// File: rtl/iq_dac_formatter.sv
// Dual-lane DAC formatter: gain registers, valid/mute pipeline and clip monitoring
// around two iq_dac_lane datapaths.
module iq_dac_formatter
  import dsp_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int MAX_SHIFT = 4,
  parameter int ROUND     = 1,
  parameter int SATURATE  = 1,
  parameter int CNT_W     = 16,
  localparam int SH_W     = clog2(MAX_SHIFT + 1)
) (
  input  logic                   pll_clock,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_i,
  input  logic signed [IN_W-1:0] in_q,
  input  logic                   shift_load,
  input  logic [SH_W-1:0]        shift_in,
  input  logic                   mute,
  input  logic                   clip_clear,
  output logic [OUT_W-1:0]       dac_i,
  output logic [OUT_W-1:0]       dac_q,
  output logic                   out_valid,
  output logic                   clip_i,
  output logic                   clip_q,
  output logic [CNT_W-1:0]       clip_count
);

  logic [SH_W-1:0] pending_shift;
  logic [SH_W-1:0] req_shift;
  logic [SH_W-1:0] eff_shift;
  logic            accept;
  logic            advance;
  logic            valid_s1;
  logic            mute_s1;
  logic            ovf_i_s1;
  logic            ovf_q_s1;
  logic            hit_i;
  logic            hit_q;

  assign accept    = clk_en & in_valid;
  assign advance   = clk_en & valid_s1;
  assign req_shift = (shift_in > SH_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : shift_in;
  // The gain in effect is latched into stage 1 with the sample, so it cannot change mid-pipeline.
  assign eff_shift = shift_load ? req_shift : pending_shift;

  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      pending_shift <= '0;
    end else if (clk_en && shift_load) begin
      pending_shift <= req_shift;
    end
  end

  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      valid_s1  <= 1'b0;
      mute_s1   <= 1'b0;
      out_valid <= 1'b0;
    end else if (clk_en) begin
      valid_s1  <= in_valid;
      out_valid <= valid_s1;
      if (in_valid) mute_s1 <= mute;
    end
  end

  iq_dac_lane #(
    .IN_W(IN_W), .OUT_W(OUT_W), .MAX_SHIFT(MAX_SHIFT), .SH_W(SH_W),
    .ROUND(ROUND), .SATURATE(SATURATE)
  ) lane_i (
    .pll_clock(pll_clock), .reset(reset), .load(accept), .shift(eff_shift),
    .sample(in_i), .advance(advance), .muted(mute_s1), .ovf(ovf_i_s1), .dac(dac_i)
  );

  iq_dac_lane #(
    .IN_W(IN_W), .OUT_W(OUT_W), .MAX_SHIFT(MAX_SHIFT), .SH_W(SH_W),
    .ROUND(ROUND), .SATURATE(SATURATE)
  ) lane_q (
    .pll_clock(pll_clock), .reset(reset), .load(accept), .shift(eff_shift),
    .sample(in_q), .advance(advance), .muted(mute_s1), .ovf(ovf_q_s1), .dac(dac_q)
  );

  assign hit_i = valid_s1 & ovf_i_s1 & ~mute_s1;
  assign hit_q = valid_s1 & ovf_q_s1 & ~mute_s1;

  // Clip events are recorded on the same edge that publishes the sample; clear wins.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      clip_i     <= 1'b0;
      clip_q     <= 1'b0;
      clip_count <= '0;
    end else if (clip_clear) begin
      clip_i     <= 1'b0;
      clip_q     <= 1'b0;
      clip_count <= '0;
    end else if (clk_en) begin
      if (hit_i) clip_i <= 1'b1;
      if (hit_q) clip_q <= 1'b1;
      if ((hit_i || hit_q) && (clip_count != '1)) clip_count <= clip_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_iq_dac_formatter.sv
// Directed bench for iq_dac_formatter: default, truncating, wrapping and
// narrow-counter instances share one stimulus stream.
module tb_iq_dac_formatter;

  logic              pll_clock = 1'b0;
  logic              reset;
  logic              clk_en;
  logic              in_valid;
  logic signed [11:0] in_i;
  logic signed [11:0] in_q;
  logic              shift_load;
  logic [2:0]        shift_in;
  logic              mute;
  logic              clip_clear;

  logic [5:0]  d_dac_i, d_dac_q, t_dac_i, t_dac_q, w_dac_i, w_dac_q, c_dac_i, c_dac_q;
  logic        d_valid, t_valid, w_valid, c_valid;
  logic        d_clip_i, d_clip_q, t_clip_i, t_clip_q, w_clip_i, w_clip_q, c_clip_i, c_clip_q;
  logic [15:0] d_count, t_count, w_count;
  logic [1:0]  c_count;

  int checks = 0;
  int passes = 0;

  always #5 pll_clock = ~pll_clock;

  iq_dac_formatter dut (
    .pll_clock(pll_clock), .reset(reset), .clk_en(clk_en), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .shift_load(shift_load), .shift_in(shift_in),
    .mute(mute), .clip_clear(clip_clear), .dac_i(d_dac_i), .dac_q(d_dac_q),
    .out_valid(d_valid), .clip_i(d_clip_i), .clip_q(d_clip_q), .clip_count(d_count)
  );

  iq_dac_formatter #(.ROUND(0)) dut_trunc (
    .pll_clock(pll_clock), .reset(reset), .clk_en(clk_en), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .shift_load(shift_load), .shift_in(shift_in),
    .mute(mute), .clip_clear(clip_clear), .dac_i(t_dac_i), .dac_q(t_dac_q),
    .out_valid(t_valid), .clip_i(t_clip_i), .clip_q(t_clip_q), .clip_count(t_count)
  );

  iq_dac_formatter #(.SATURATE(0)) dut_wrap (
    .pll_clock(pll_clock), .reset(reset), .clk_en(clk_en), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .shift_load(shift_load), .shift_in(shift_in),
    .mute(mute), .clip_clear(clip_clear), .dac_i(w_dac_i), .dac_q(w_dac_q),
    .out_valid(w_valid), .clip_i(w_clip_i), .clip_q(w_clip_q), .clip_count(w_count)
  );

  iq_dac_formatter #(.CNT_W(2)) dut_c2 (
    .pll_clock(pll_clock), .reset(reset), .clk_en(clk_en), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .shift_load(shift_load), .shift_in(shift_in),
    .mute(mute), .clip_clear(clip_clear), .dac_i(c_dac_i), .dac_q(c_dac_q),
    .out_valid(c_valid), .clip_i(c_clip_i), .clip_q(c_clip_q), .clip_count(c_count)
  );

  typedef struct {
    logic signed [11:0] i;
    logic signed [11:0] q;
    int di, dq, ti, tq, wi, wq;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge pll_clock);
    #1;
  endtask

  task automatic applyStimulus(input logic signed [11:0] i, input logic signed [11:0] q,
                               input logic m, input logic ld, input logic [2:0] sh);
    in_i = i; in_q = q; mute = m; shift_load = ld; shift_in = sh; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; shift_load = 1'b0; mute = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{12'sd0,    12'sd64,    32, 33, 32, 33, 32, 33};
    vecs[1] = '{12'sd31,   12'sd32,    32, 33, 32, 32, 32, 33};
    vecs[2] = '{12'sd63,  -12'sd2048,  33,  0, 32,  0, 33,  0};
    vecs[3] = '{-12'sd1,  -12'sd33,    32, 31, 31, 31, 32, 31};
    vecs[4] = '{12'sd1000, -12'sd1000, 48, 16, 47, 16, 48, 16};
    vecs[5] = '{12'sd2015, -12'sd2016, 63,  1, 63,  0, 63,  1};

    reset = 1'b1; clk_en = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0;
    shift_load = 1'b0; shift_in = '0; mute = 1'b0; clip_clear = 1'b0;
    tick(); tick();
    checkOutput("reset dac_i", d_dac_i, 32);
    checkOutput("reset dac_q", d_dac_q, 32);
    checkOutput("reset out_valid", d_valid, 0);
    checkOutput("reset clip_count", d_count, 0);
    checkOutput("reset clip_i", d_clip_i, 0);
    reset = 1'b0;
    tick();

    // Rounding / truncation table at unity gain
    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k].i, vecs[k].q, 1'b0, 1'b0, 3'd0);
      checkOutput($sformatf("vec%0d out_valid", k), d_valid, 1);
      checkOutput($sformatf("vec%0d round dac_i", k), d_dac_i, vecs[k].di);
      checkOutput($sformatf("vec%0d round dac_q", k), d_dac_q, vecs[k].dq);
      checkOutput($sformatf("vec%0d trunc dac_i", k), t_dac_i, vecs[k].ti);
      checkOutput($sformatf("vec%0d trunc dac_q", k), t_dac_q, vecs[k].tq);
      checkOutput($sformatf("vec%0d wrap dac_i", k), w_dac_i, vecs[k].wi);
      checkOutput($sformatf("vec%0d wrap dac_q", k), w_dac_q, vecs[k].wq);
    end
    checkOutput("table clip_count", d_count, 0);
    checkOutput("table wrap clip_count", w_count, 0);

    // Saturation vs wrap
    applyStimulus(12'sd2047, 12'sd0, 1'b0, 1'b0, 3'd0);
    checkOutput("sat dac_i", d_dac_i, 63);
    checkOutput("sat dac_q", d_dac_q, 32);
    checkOutput("sat clip_i", d_clip_i, 1);
    checkOutput("sat clip_q", d_clip_q, 0);
    checkOutput("sat clip_count", d_count, 1);
    checkOutput("wrap dac_i", w_dac_i, 0);
    checkOutput("wrap clip_i", w_clip_i, 1);
    checkOutput("trunc no-clip dac_i", t_dac_i, 63);
    checkOutput("trunc no-clip clip_i", t_clip_i, 0);
    applyStimulus(12'sd2016, -12'sd2048, 1'b0, 1'b0, 3'd0);
    checkOutput("sat2 dac_i", d_dac_i, 63);
    checkOutput("sat2 dac_q", d_dac_q, 0);
    checkOutput("sat2 clip_count", d_count, 2);
    checkOutput("wrap2 dac_i", w_dac_i, 0);
    checkOutput("trunc2 clip_count", t_count, 0);

    // clip_clear with clk_en low
    clk_en = 1'b0; clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0; clk_en = 1'b1;
    checkOutput("clear clip_i", d_clip_i, 0);
    checkOutput("clear clip_count", d_count, 0);
    checkOutput("clear wrap clip_i", w_clip_i, 0);
    checkOutput("clear c2 count", c_count, 0);

    // clip_clear beats a same-cycle clip
    in_i = 12'sd2047; in_q = 12'sd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    checkOutput("clrprio out_valid", d_valid, 1);
    checkOutput("clrprio dac_i", d_dac_i, 63);
    checkOutput("clrprio clip_i", d_clip_i, 0);
    checkOutput("clrprio clip_count", d_count, 0);

    // Mute
    applyStimulus(12'sd2047, 12'sd100, 1'b1, 1'b0, 3'd0);
    checkOutput("mute out_valid", d_valid, 1);
    checkOutput("mute dac_i", d_dac_i, 32);
    checkOutput("mute dac_q", d_dac_q, 32);
    checkOutput("mute clip_i", d_clip_i, 0);
    checkOutput("mute clip_count", d_count, 0);

    // Counter saturation on the 2-bit instance
    for (int k = 0; k < 5; k++) applyStimulus(12'sd2047, 12'sd0, 1'b0, 1'b0, 3'd0);
    checkOutput("cnt5 clip_count", d_count, 5);
    checkOutput("cnt5 c2 count", c_count, 3);
    checkOutput("cnt5 clip_q", d_clip_q, 0);

    // Gain loading and timing
    shift_load = 1'b1; shift_in = 3'd2;
    tick();
    shift_load = 1'b0;
    applyStimulus(12'sd300, -12'sd300, 1'b0, 1'b0, 3'd0);
    checkOutput("gain2 dac_i", d_dac_i, 51);
    checkOutput("gain2 dac_q", d_dac_q, 13);
    shift_load = 1'b1; shift_in = 3'd7;
    tick();
    shift_load = 1'b0;
    applyStimulus(12'sd100, 12'sd0, 1'b0, 1'b0, 3'd0);
    checkOutput("gain clamp dac_i", d_dac_i, 57);
    in_i = 12'sd100; in_q = 12'sd0; in_valid = 1'b1; shift_load = 1'b1; shift_in = 3'd1;
    tick();
    in_valid = 1'b0; shift_in = 3'd3;
    tick();
    shift_load = 1'b0;
    checkOutput("inflight dac_i", d_dac_i, 35);
    in_i = 12'sd100; in_valid = 1'b1;
    tick();
    in_i = -12'sd100;
    tick();
    checkOutput("b2b first valid", d_valid, 1);
    checkOutput("b2b first dac_i", d_dac_i, 45);
    in_valid = 1'b0;
    tick();
    checkOutput("b2b second valid", d_valid, 1);
    checkOutput("b2b second dac_i", d_dac_i, 20);
    tick();
    checkOutput("b2b end valid", d_valid, 0);

    // Negative overflow at gain 1
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    applyStimulus(12'sd0, -12'sd2048, 1'b0, 1'b1, 3'd1);
    checkOutput("negsat dac_q", d_dac_q, 0);
    checkOutput("negsat clip_q", d_clip_q, 1);
    checkOutput("negsat clip_i", d_clip_i, 0);
    checkOutput("negwrap dac_q", w_dac_q, 32);
    checkOutput("negwrap clip_q", w_clip_q, 1);
    shift_load = 1'b1; shift_in = 3'd0;
    tick();
    shift_load = 1'b0;

    // clk_en freeze mid-pipeline
    in_i = 12'sd1000; in_q = -12'sd1000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clk_en = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checkOutput("freeze out_valid", d_valid, 0);
    checkOutput("freeze dac_i", d_dac_i, 32);
    clk_en = 1'b1;
    tick();
    checkOutput("resume out_valid", d_valid, 1);
    checkOutput("resume dac_i", d_dac_i, 48);
    checkOutput("resume dac_q", d_dac_q, 16);
    tick();
    checkOutput("resume single pulse", d_valid, 0);

    // Reset with a sample in flight
    in_i = 12'sd2047; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; reset = 1'b1;
    #1;
    checkOutput("midreset dac_i", d_dac_i, 32);
    checkOutput("midreset clip_count", d_count, 0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("midreset discarded", d_valid, 0);
    checkOutput("midreset dac_i hold", d_dac_i, 32);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/iq_dac_formatter.md
Name: iq_dac_formatter

Overview:
Parametrised output stage between a complex mixer and a pair of offset-binary DACs. Accepts signed I/Q samples of IN_W bits and applies a runtime power-of-two gain. Rounds or truncates to OUT_W bits, saturates or wraps, and converts to offset binary. Adds sample-valid handshake, mute, and clip monitoring, and generalises the fixed "take top bits, add midscale" DAC path.

Parameters:
IN_W, 12, input sample width (signed)
OUT_W, 6, DAC width (unsigned offset binary); requires OUT_W < IN_W
MAX_SHIFT, 4, largest gain left-shift; SH_W = clog2(MAX_SHIFT+1)
ROUND, 1, 1 = round-half-up on dropped bits, 0 = truncate (floor)
SATURATE, 1, 1 = clamp out-of-range results, 0 = wrap (keep low OUT_W bits)
CNT_W, 16, clip counter width

Ports:
pll_clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high
clk_en  input  1  global enable; when low, all registers hold
in_valid  input  1  sample strobe; in_i/in_q accepted when clk_en & in_valid
in_i  input  IN_W  signed I sample
in_q  input  IN_W  signed Q sample
shift_load  input  1  latch shift_in into the pending-gain register
shift_in  input  SH_W  requested gain shift, values above MAX_SHIFT clamp to MAX_SHIFT
mute  input  1  force midscale on samples accepted while high
clip_clear  input  1  clear sticky flags and counter
dac_i  output  OUT_W  I DAC code
dac_q  output  OUT_W  Q DAC code
out_valid  output  1  dac_i/dac_q updated this cycle
clip_i  output  1  sticky I overflow flag
clip_q  output  1  sticky Q overflow flag
clip_count  output  CNT_W  saturating count of clipped samples

Behaviour:
- Reset (async assert, sync release):
  - dac_i = dac_q = 2^(OUT_W-1) (midscale; 32 for OUT_W=6).
  - out_valid = 0, clip flags 0, clip_count 0.
  - Active and pending shift = 0.
- Gain register:
  - shift_load stores shift_in in the pending register.
  - Pending copies to active only on an accepted sample, and that sample already uses the new value. Gain never changes mid-pipeline.
  - shift_load on the same cycle as acceptance: the newly loaded value is used.
- Pipeline: 2 cycles from acceptance to out_valid=1, all stages gated by clk_en. out_valid is a 1-cycle pulse per accepted sample. Back-to-back samples give back-to-back pulses.
- Stage 1, per channel:
  - Sign-extend to IN_W+MAX_SHIFT+1 bits and arithmetic-shift left by the active shift.
  - If ROUND=1, add 2^(D-1), where D = IN_W-OUT_W.
  - Arithmetic-shift right by D to get r.
  - Register r, an overflow bit (r outside [-2^(OUT_W-1), 2^(OUT_W-1)-1]), and the mute state.
- Stage 2, per channel:
  - Overflow with SATURATE=1: clamp r to the nearer bound.
  - Overflow with SATURATE=0: keep the low OUT_W bits.
  - Invert the MSB to form offset binary.
  - Muted sample: output midscale, and no clip is recorded for it.
- Clip monitoring:
  - On an out_valid cycle with overflow, set that channel's sticky flag.
  - clip_count increments by 1 per sample where either channel overflowed. It saturates at all-ones with no wrap.
  - clip_clear takes priority over a same-cycle set or increment.
  - clip_clear acts even when clk_en=0.
- clk_en low mid-pipeline: data is frozen and resumes intact when clk_en returns. No sample is lost or duplicated.
- Reset mid-operation: in-flight samples are discarded and outputs return to midscale immediately.

Decomposition:
- Shared package dsp_pkg holds:
  - a midscale function MID(w) = 2^(w-1)
  - a clog2 helper
  - localparam D = IN_W-OUT_W
- One natural sub-module, iq_dac_lane, holds a single channel's stage-1/stage-2 datapath plus its overflow flag. It is instantiated twice (I and Q).
- The top holds the gain registers, handshake/valid pipeline, mute pipe and clip counter.

Test Plan:
All cases use default parameters unless stated.
- Reset -> dac_i=dac_q=32, out_valid=0, clip_count=0. Accept in_i=0, in_q=64, shift=0 -> two cycles later out_valid=1, dac_i=32, dac_q=33.
- Rounding boundary: in_i=31 -> 32, in_i=32 -> 33, in_q=-2048 -> 0. With ROUND=0: in_i=63 -> 32, in_q=-1 -> 31.
- Saturation: in_i=2047 -> dac_i=63, clip_i=1, clip_count=1. Repeat with SATURATE=0 -> dac_i=0, clip_i=1. clip_clear -> flags 0, count 0.
- Gain timing: shift_load shift_in=2 with no sample pending, then accept in_i=300 -> dac_i=51. Load shift_in=7 -> clamps to 4. A sample already in flight keeps its old shift.
- Mute/clk_en: mute with in_i=2047 -> dac_i=32 and no clip recorded. Drop clk_en for 5 cycles mid-pipeline -> output appears exactly 2 enabled cycles after acceptance, values unchanged.
- Counter saturation (CNT_W=2): 5 clipped samples -> clip_count=3.
